snd_buffer: RTL and testbench

SND_BUFFER -- requirements
Module: snd_buffer

---
 rtl/snd_pkg.sv | 32 +++
 rtl/snd_buffer_if.sv | 36 +++
 rtl/snd_fifo_ram.sv | 25 ++
 rtl/snd_buffer.sv | 143 ++++++++++++++
 tb/tb_snd_buffer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/snd_pkg.sv
// Sound buffer shared types and constants.
// Word layout: two stereo samples per 64-bit VRAM word.
package snd_pkg;

   localparam int DEPTH_DEF = 16;
   localparam int WORD_W    = 64;
   localparam int SMP_W     = 16;
   localparam int PAIR_W    = 2 * SMP_W;
   localparam int S0_LSB    = 0;
   localparam int S1_LSB    = 32;
   localparam int L_LSB     = 0;
   localparam int R_LSB     = 16;

   typedef struct packed {
      logic [SMP_W-1:0] r;
      logic [SMP_W-1:0] l;
   } smp_t;

   function automatic smp_t pick_smp(
      input logic [WORD_W-1:0] w,
      input logic              half
   );
      logic [PAIR_W-1:0] p;
      smp_t              s;
      p   = half ? w[S1_LSB +: PAIR_W]
                 : w[S0_LSB +: PAIR_W];
      s.l = p[L_LSB +: SMP_W];
      s.r = p[R_LSB +: SMP_W];
      return s;
   endfunction

endpackage

// File: rtl/snd_buffer_if.sv
// Sound buffer bus bundle: VRAM read side,
// play control and audio sample output.
interface snd_buffer_if;
   import snd_pkg::*;

   logic              SND_VRAMREQ;
   logic              VIF_SNDACK;
   logic              VIF_SNDRDATAVLD;
   logic [WORD_W-1:0] VIF_RDATA;
   logic              PLAY_NOW;
   logic              SMP_TICK;
   logic              FLUSH;
   logic              BUF_WREADY;
   logic [SMP_W-1:0]  SND_LDATA;
   logic [SMP_W-1:0]  SND_RDATA;
   logic              SND_VALID;
   logic              UNDERRUN;
   logic              OVERFLOW;

   modport master (
      output SND_VRAMREQ, VIF_SNDACK,
      output VIF_SNDRDATAVLD, VIF_RDATA,
      output PLAY_NOW, SMP_TICK, FLUSH,
      input  BUF_WREADY, SND_LDATA, SND_RDATA,
      input  SND_VALID, UNDERRUN, OVERFLOW
   );

   modport slave (
      input  SND_VRAMREQ, VIF_SNDACK,
      input  VIF_SNDRDATAVLD, VIF_RDATA,
      input  PLAY_NOW, SMP_TICK, FLUSH,
      output BUF_WREADY, SND_LDATA, SND_RDATA,
      output SND_VALID, UNDERRUN, OVERFLOW
   );

endinterface

// File: rtl/snd_fifo_ram.sv
// Sound FIFO storage: DEPTH x 64 words,
// synchronous write, asynchronous read.
module snd_fifo_ram
   import snd_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/snd_buffer.sv
// Sound sample buffer: stores VRAM read words and
// plays one stereo sample per SMP_TICK.
module snd_buffer
   import snd_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input logic         CLK,
   input logic         RST_X,
   snd_buffer_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = AW + 2;

   generate
      if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad
         $error("snd_buffer: DEPTH must be a power of two >= 4");
      end
   endgenerate

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     used;
   logic [CW-1:0]     pending;
   logic              half_sel;
   logic [WORD_W-1:0] head;
   smp_t              smp;

   logic req_acc;
   logic vld;
   logic full;
   logic empty;
   logic play_tick;
   logic take;
   logic pop;
   logic wr_en;
   logic ovf_set;
   logic unf_set;

   logic [CW-1:0] used_nxt;
   logic [CW-1:0] pend_nxt;
   logic [SW-1:0] occ_sum;

   assign req_acc   = bus.SND_VRAMREQ & bus.VIF_SNDACK;
   assign vld       = bus.VIF_SNDRDATAVLD;
   assign full      = (used == CW'(DEPTH));
   assign empty     = (used == '0);
   assign play_tick = bus.SMP_TICK & bus.PLAY_NOW & ~bus.FLUSH;
   assign take      = play_tick & ~empty;
   assign pop       = take & half_sel;
   // A pop frees the head slot in time for a write into a full FIFO.
   assign wr_en     = vld & ~bus.FLUSH & (~full | pop);
   assign ovf_set   = vld & ~bus.FLUSH & full & ~pop;
   assign unf_set   = play_tick & empty;

   assign occ_sum        = {1'b0, used} + {1'b0, pending};
   assign bus.BUF_WREADY = (occ_sum < SW'(DEPTH));

   always_comb begin
      used_nxt = used;
      pend_nxt = pending;
      unique case ({req_acc, vld})
         2'b10:   pend_nxt = pending + CW'(1);
         2'b01:   pend_nxt = pending - CW'(1);
         default: pend_nxt = pending;
      endcase
      if (bus.FLUSH) begin
         used_nxt = '0;
      end else begin
         unique case ({wr_en, pop})
            2'b10:   used_nxt = used + CW'(1);
            2'b01:   used_nxt = used - CW'(1);
            default: used_nxt = used;
         endcase
      end
   end

   snd_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .CLK   (CLK),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (bus.VIF_RDATA),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign smp = pick_smp(head, half_sel);

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         used     <= '0;
         pending  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         half_sel <= 1'b0;
      end else begin
         used    <= used_nxt;
         pending <= pend_nxt;
         if (bus.FLUSH) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            half_sel <= 1'b0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (take)  half_sel <= ~half_sel;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         bus.SND_LDATA <= '0;
         bus.SND_RDATA <= '0;
         bus.SND_VALID <= 1'b0;
      end else begin
         bus.SND_VALID <= bus.SMP_TICK;
         if (bus.SMP_TICK) begin
            bus.SND_LDATA <= take ? smp.l : '0;
            bus.SND_RDATA <= take ? smp.r : '0;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         bus.UNDERRUN <= 1'b0;
         bus.OVERFLOW <= 1'b0;
      end else if (bus.FLUSH) begin
         bus.UNDERRUN <= 1'b0;
         bus.OVERFLOW <= 1'b0;
      end else begin
         if (unf_set) bus.UNDERRUN <= 1'b1;
         if (ovf_set) bus.OVERFLOW <= 1'b1;
      end
   end

endmodule

// File: tb/tb_snd_buffer.sv
// Directed bench for snd_buffer: credit accounting,
// sample order, flags, flush and reset behaviour.
module tb_snd_buffer;

   logic CLK;
   logic RST_X;
   int   n_cmp;
   int   n_err;

   snd_buffer_if bif ();

   snd_buffer #(
      .DEPTH (16)
   ) dut (
      .CLK   (CLK),
      .RST_X (RST_X),
      .bus   (bif.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wd(input int i);
      logic [15:0] b;
      b = 16'(i * 4);
      return {b + 16'd3, b + 16'd2, b + 16'd1, b};
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic cyc(
      input logic        req,
      input logic        vld,
      input logic [63:0] d,
      input logic        tick,
      input logic        flush
   );
      bif.SND_VRAMREQ     = req;
      bif.VIF_SNDACK      = req;
      bif.VIF_SNDRDATAVLD = vld;
      bif.VIF_RDATA       = d;
      bif.SMP_TICK        = tick;
      bif.FLUSH           = flush;
      step();
      bif.SND_VRAMREQ     = 1'b0;
      bif.VIF_SNDACK      = 1'b0;
      bif.VIF_SNDRDATAVLD = 1'b0;
      bif.SMP_TICK        = 1'b0;
      bif.FLUSH           = 1'b0;
   endtask

   task automatic do_reset();
      RST_X = 1'b0;
      #2;
      @(negedge CLK);
      RST_X = 1'b1;
      step();
   endtask

   function automatic logic [31:0] lr();
      return {bif.SND_RDATA, bif.SND_LDATA};
   endfunction

   logic [63:0] w;

   initial begin
      n_cmp = 0;
      n_err = 0;
      RST_X = 1'b1;
      bif.SND_VRAMREQ     = 1'b0;
      bif.VIF_SNDACK      = 1'b0;
      bif.VIF_SNDRDATAVLD = 1'b0;
      bif.VIF_RDATA       = '0;
      bif.PLAY_NOW        = 1'b1;
      bif.SMP_TICK        = 1'b0;
      bif.FLUSH           = 1'b0;
      #3;
      RST_X = 1'b0;
      #2;
      chk("rst_used", 64'(dut.used), 64'd0);
      chk("rst_pend", 64'(dut.pending), 64'd0);
      chk("rst_wrdy", 64'(bif.BUF_WREADY), 64'd1);
      chk("rst_valid", 64'(bif.SND_VALID), 64'd0);
      chk("rst_lr", 64'(lr()), 64'd0);
      chk("rst_flags", {62'd0, bif.UNDERRUN, bif.OVERFLOW}, 64'd0);
      @(negedge CLK);
      RST_X = 1'b1;
      step();

      // credit accounting: 16 requests with nothing returned
      for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0, 0);
      chk("cred_15", 64'(bif.BUF_WREADY), 64'd1);
      cyc(1, 0, 0, 0, 0);
      chk("cred_16", 64'(bif.BUF_WREADY), 64'd0);
      cyc(0, 1, 64'h0004_0003_0002_0001, 0, 0);
      chk("cred_vld", 64'(bif.BUF_WREADY), 64'd0);
      chk("cred_used", 64'(dut.used), 64'd1);
      cyc(0, 0, 0, 1, 0);
      chk("cred_t1", 64'(lr()), 64'h0002_0001);
      chk("cred_t1w", 64'(bif.BUF_WREADY), 64'd0);
      cyc(0, 0, 0, 1, 0);
      chk("cred_t2", 64'(lr()), 64'h0004_0003);
      chk("cred_pop", 64'(bif.BUF_WREADY), 64'd1);
      chk("cred_pend", 64'(dut.pending), 64'd15);
      do_reset();
      chk("mid_rst_pend", 64'(dut.pending), 64'd0);
      chk("mid_rst_wrdy", 64'(bif.BUF_WREADY), 64'd1);

      // basic play order
      cyc(0, 1, 64'h0004_0003_0002_0001, 0, 0);
      chk("play_used1", 64'(dut.used), 64'd1);
      cyc(0, 0, 0, 1, 0);
      chk("play_v1", 64'(bif.SND_VALID), 64'd1);
      chk("play_s0", 64'(lr()), 64'h0002_0001);
      cyc(0, 0, 0, 0, 0);
      chk("hold_v", 64'(bif.SND_VALID), 64'd0);
      chk("hold_lr", 64'(lr()), 64'h0002_0001);
      cyc(0, 0, 0, 1, 0);
      chk("play_s1", 64'(lr()), 64'h0004_0003);
      chk("play_used0", 64'(dut.used), 64'd0);

      // not playing: zero output, no flag
      bif.PLAY_NOW = 1'b0;
      cyc(0, 0, 0, 1, 0);
      chk("stop_v", 64'(bif.SND_VALID), 64'd1);
      chk("stop_lr", 64'(lr()), 64'd0);
      chk("stop_unf", 64'(bif.UNDERRUN), 64'd0);
      bif.PLAY_NOW = 1'b1;

      // underrun and sticky behaviour
      cyc(0, 0, 0, 1, 0);
      chk("unf_v", 64'(bif.SND_VALID), 64'd1);
      chk("unf_lr", 64'(lr()), 64'd0);
      chk("unf_set", 64'(bif.UNDERRUN), 64'd1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
      chk("unf_stick", 64'(bif.UNDERRUN), 64'd1);
      cyc(0, 0, 0, 1, 1);
      chk("fl_tick_v", 64'(bif.SND_VALID), 64'd1);
      chk("fl_tick_lr", 64'(lr()), 64'd0);
      chk("fl_unf", 64'(bif.UNDERRUN), 64'd0);

      // overflow on a full FIFO
      do_reset();
      for (int i = 0; i < 16; i++) cyc(0, 1, wd(i), 0, 0);
      chk("full_used", 64'(dut.used), 64'd16);
      chk("full_wrdy", 64'(bif.BUF_WREADY), 64'd0);
      cyc(0, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0);
      chk("ovf_set", 64'(bif.OVERFLOW), 64'd1);
      chk("ovf_used", 64'(dut.used), 64'd16);
      for (int i = 0; i < 16; i++) begin
         w = wd(i);
         cyc(0, 0, 0, 1, 0);
         chk($sformatf("ovf_w%0d_s0", i), 64'(lr()), 64'(w[31:0]));
         cyc(0, 0, 0, 1, 0);
         chk($sformatf("ovf_w%0d_s1", i), 64'(lr()), 64'(w[63:32]));
      end
      chk("ovf_drain", 64'(dut.used), 64'd0);
      chk("ovf_stick", 64'(bif.OVERFLOW), 64'd1);

      // simultaneous write and pop
      do_reset();
      for (int i = 0; i < 5; i++) cyc(0, 1, wd(i), 0, 0);
      cyc(0, 0, 0, 1, 0);
      chk("wp_used_pre", 64'(dut.used), 64'd5);
      cyc(0, 1, wd(5), 1, 0);
      w = wd(0);
      chk("wp_used", 64'(dut.used), 64'd5);
      chk("wp_wptr", 64'(dut.wr_ptr), 64'd6);
      chk("wp_rptr", 64'(dut.rd_ptr), 64'd1);
      chk("wp_lr", 64'(lr()), 64'(w[63:32]));

      // flush with requests in flight
      do_reset();
      cyc(0, 0, 0, 1, 0);
      chk("fl_unf_pre", 64'(bif.UNDERRUN), 64'd1);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
      cyc(0, 1, wd(100), 0, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1);
      chk("fl_used", 64'(dut.used), 64'd0);
      chk("fl_pend", 64'(dut.pending), 64'd3);
      chk("fl_half", 64'(dut.half_sel), 64'd0);
      for (int i = 0; i < 3; i++) cyc(0, 1, wd(200 + i), 0, 0);
      chk("fl_used3", 64'(dut.used), 64'd3);
      chk("fl_pend0", 64'(dut.pending), 64'd0);
      chk("fl_flags", {62'd0, bif.UNDERRUN, bif.OVERFLOW}, 64'd0);
      cyc(0, 0, 0, 1, 0);
      w = wd(200);
      chk("fl_first", 64'(lr()), 64'(w[31:0]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
